// File: rtl/add_pkg.sv
// Shared word width and FSM state encoding for the 64-bit accumulator.
package add_pkg;

  localparam int WORD_W = 64;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ACCUM = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage : add_pkg

// File: rtl/full_adder_64bit.sv
// 64-bit ripple-free adder with carry in/out.
// Latency: combinational.
// Backpressure: none (pure datapath).
module full_adder_64bit
  import add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              carry_in,
  output logic [WORD_W-1:0] sum,
  output logic              carry_out
);

  logic [WORD_W:0] wide_sum;

  assign wide_sum  = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, carry_in};
  assign sum       = wide_sum[WORD_W-1:0];
  assign carry_out = wide_sum[WORD_W];

endmodule : full_adder_64bit

// File: rtl/add_accum64.sv
// Accumulates a counted run of 64-bit beats, tracking carry-outs and signed overflow.
// Latency: out_valid rises the cycle after the last beat is accepted (next cycle for count=0).
// Backpressure: in_ready only in ACCUM; result held in DONE until out_valid && out_ready.
module add_accum64
  import add_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] sum,
  output logic [CNT_W-1:0]  carry_count,
  output logic              ovf,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state;
  logic [WORD_W-1:0] acc;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  carry_q;
  logic              ovf_q;

  logic [WORD_W-1:0] add_sum;
  logic              add_carry;
  logic              beat;
  logic              beat_ovf;

  full_adder_64bit u_adder (
    .a         (acc),
    .b         (in_data),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_carry)
  );

  assign beat     = in_valid && in_ready;
  // Signed overflow: both operands share a sign that the result does not.
  assign beat_ovf = (acc[WORD_W-1] == in_data[WORD_W-1]) &&
                    (add_sum[WORD_W-1] != acc[WORD_W-1]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      carry_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            if (count != '0) begin
              remaining <= count;
              state     <= ACCUM;
            end else begin
              remaining <= '0;
              state     <= DONE;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            acc       <= add_sum;
            remaining <= remaining - CNT_ONE;
            if (add_carry && (carry_q != CNT_MAX)) carry_q <= carry_q + CNT_ONE;
            if (beat_ovf) ovf_q <= 1'b1;
            if (remaining == CNT_ONE) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state == ACCUM);
  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign sum         = acc;
  assign carry_count = carry_q;
  assign ovf         = ovf_q;

endmodule : add_accum64

// File: tb/tb_add_accum64.sv
// Randomized and directed self-checking bench for add_accum64 against a run-level reference model.
module tb_add_accum64;

  localparam int CNT_W = 8;

  logic              clock;
  logic              reset;
  logic              start;
  logic [CNT_W-1:0]  count;
  logic              in_valid;
  logic [63:0]       in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       sum;
  logic [CNT_W-1:0]  carry_count;
  logic              ovf;
  logic              busy;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  logic [63:0] beats [0:31];

  add_accum64 #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .count       (count),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .carry_count (carry_count),
    .ovf         (ovf),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    case ($urandom_range(3))
      0: rand_word = w;
      1: rand_word = 64'(w[7:0]);
      2: rand_word = 64'hFFFF_FFFF_FFFF_FF00 | 64'(w[7:0]);
      default: rand_word = 64'h7FFF_FFFF_FFFF_FF00 | 64'(w[7:0]);
    endcase
  endfunction

  // Runs one transaction from IDLE: n beats from beats[], random stalls, hold cycles in DONE.
  task automatic run_case(input string tag, input int n, input int stall_pct, input int hold);
    logic [63:0]        m_sum;
    int                 m_cy;
    logic               m_ovf;
    logic signed [64:0] ws;
    logic [64:0]        wu;
    int                 idx;
    int                 budget;
    logic               take;

    m_sum = '0; m_cy = 0; m_ovf = 1'b0; idx = 0; budget = 0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    start     = 1'b1;
    count     = CNT_W'(n);
    tick();
    start = 1'b0;
    chk({tag, ".busy"}, 64'(busy), 64'd1);

    while (idx < n && budget < 4 * n + 16) begin
      chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, ".ov_low"}, 64'(out_valid), 64'd0);
      chk({tag, ".live_sum"}, sum, m_sum);
      in_valid = ($urandom_range(99) >= stall_pct);
      in_data  = in_valid ? beats[idx] : rand_word();
      start    = $urandom_range(1) == 1;
      count    = CNT_W'($urandom);
      take     = in_valid;
      tick();
      start = 1'b0;
      if (take) begin
        wu = {1'b0, m_sum} + {1'b0, beats[idx]};
        if (wu[64] && m_cy < (1 << CNT_W) - 1) m_cy++;
        ws = $signed({m_sum[63], m_sum}) + $signed({beats[idx][63], beats[idx]});
        if (ws > 65'sh0_7FFF_FFFF_FFFF_FFFF || ws < -65'sh0_8000_0000_0000_0000) m_ovf = 1'b1;
        m_sum = wu[63:0];
        idx++;
      end
      budget++;
    end
    in_valid = 1'b0;
    if (idx < n) chk({tag, ".beat_timeout"}, 64'(idx), 64'(n));

    chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".in_ready_done"}, 64'(in_ready), 64'd0);
    chk({tag, ".sum"}, sum, m_sum);
    chk({tag, ".carry"}, 64'(carry_count), 64'(m_cy));
    chk({tag, ".ovf"}, 64'(ovf), 64'(m_ovf));

    for (int h = 0; h < hold; h++) begin
      start = $urandom_range(1) == 1;
      count = CNT_W'($urandom_range(1, 9));
      tick();
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_sum"}, sum, m_sum);
      chk({tag, ".hold_ovf"}, 64'(ovf), 64'(m_ovf));
    end

    out_ready = 1'b1;
    start     = $urandom_range(1) == 1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
    chk({tag, ".idle_sum"}, sum, m_sum);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; count = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.sum", sum, 64'd0);
    chk("rst.carry", 64'(carry_count), 64'd0);
    chk("rst.ovf", 64'(ovf), 64'd0);
    reset = 1'b0;
    tick();

    beats[0] = 64'd1; beats[1] = 64'd2;
    run_case("simple", 2, 0, 0);
    beats[0] = 64'hFFFF_FFFF_FFFF_FFFF; beats[1] = 64'd1;
    run_case("carry", 2, 0, 0);
    beats[0] = 64'h7FFF_FFFF_FFFF_FFFF; beats[1] = 64'd1;
    run_case("ovf", 2, 0, 0);
    run_case("zero", 0, 0, 0);
    beats[0] = 64'd5;
    run_case("hold", 1, 0, 3);

    // Abort mid-run with an asynchronous reset pulse.
    start = 1'b1; count = CNT_W'(3);
    tick();
    start = 1'b0; in_valid = 1'b1; in_data = 64'h1234;
    tick();
    in_valid = 1'b0;
    chk("abort.pre_sum", sum, 64'h1234);
    #2 reset = 1'b1;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.in_ready", 64'(in_ready), 64'd0);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.sum", sum, 64'd0);
    chk("abort.carry", 64'(carry_count), 64'd0);
    chk("abort.ovf", 64'(ovf), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort.idle_valid", 64'(out_valid), 64'd0);
    beats[0] = 64'hA5;
    run_case("after_abort", 1, 0, 0);

    for (int r = 0; r < 30; r++) begin
      int n;
      n = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 24);
      for (int i = 0; i < 32; i++) beats[i] = rand_word();
      run_case($sformatf("rand%0d", r), n, $urandom_range(40), $urandom_range(3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_add_accum64

// File: doc/add_accum64.md
ADD_ACCUM64 -- requirements
Module: add_accum64

Interface
REQ-001 Parameter CNT_W, default 8, width of beat count and carry counter.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-005 count  input  CNT_W  number of operand beats to accumulate, sampled with start.
REQ-006 in_valid  input  1  operand beat present.
REQ-007 in_data  input  64  unsigned/two's-complement operand.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 sum  output  64  accumulated sum modulo 2^64.
REQ-012 carry_count  output  CNT_W  number of adder carry-outs during the run, saturating.
REQ-013 ovf  output  1  sticky signed-overflow flag for the run.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, DONE.
REQ-016 IDLE: start=1 and count>0 SHALL load remaining=count, clear acc/carry_count/ovf, go to ACCUM next cycle.
REQ-017 IDLE: start=1 and count=0 SHALL clear acc/carry_count/ovf and go directly to DONE (sum=0).
REQ-018 in_ready SHALL be 1 exactly when state is ACCUM; a beat is accepted when in_valid and in_ready are both 1.
REQ-019 Each accepted beat SHALL update acc <= acc + in_data (carry_in=0) in the same clock edge.
REQ-020 Adder carry_out=1 on an accepted beat SHALL increment carry_count, saturating at 2^CNT_W-1.
REQ-021 ovf SHALL set when acc[63]==in_data[63] and new sum[63] differs; once set it stays set until next start or reset.
REQ-022 remaining SHALL decrement per accepted beat; acceptance of the beat with remaining=1 SHALL move to DONE.
REQ-023 in_valid=0 in ACCUM SHALL hold all state (no timeout).
REQ-024 Latency: out_valid SHALL assert the cycle after the last beat is accepted.
REQ-025 DONE: out_valid=1; sum, carry_count, ovf SHALL be stable until out_valid&&out_ready, then IDLE next cycle.
REQ-026 start SHALL be ignored in ACCUM and DONE; a new start is honoured only once back in IDLE.
REQ-027 out_valid SHALL be 0 in IDLE and ACCUM; sum/carry_count/ovf SHALL show live acc values in all states.

Reset
REQ-028 reset SHALL immediately (asynchronously) force state=IDLE, acc=0, remaining=0, carry_count=0, ovf=0.
REQ-029 During and after reset: in_ready=0, out_valid=0, busy=0, sum=0, carry_count=0, ovf=0.
REQ-030 reset mid-ACCUM or mid-DONE SHALL discard the run; no partial result is presented.

Structure
REQ-031 Shared package add_pkg SHALL hold WORD_W=64 and the FSM state typedef (IDLE/ACCUM/DONE).
REQ-032 The 64-bit add SHALL be one instance of full_adder_64bit (A=acc, B=in_data, carry_in=0); no other sub-modules.

Verification
REQ-033 Reset, start count=2, beats 1 then 2 -> out_valid one cycle after beat 2, sum=3, carry_count=0, ovf=0.
REQ-034 count=2, beats FFFF_FFFF_FFFF_FFFF and 1 -> sum=0, carry_count=1, ovf=0.
REQ-035 count=2, beats 7FFF_FFFF_FFFF_FFFF and 1 -> sum=8000_0000_0000_0000, carry_count=0, ovf=1.
REQ-036 start with count=0 -> out_valid next cycle, sum=0, in_ready never asserted.
REQ-037 count=1 beat 5, out_ready low 3 cycles with start pulsed in DONE -> out_valid and sum=5 held, start ignored, IDLE after handshake.
REQ-038 count=3, reset asserted after 1 beat -> same-cycle IDLE, all outputs 0; fresh count=1 beat A5 run yields sum=A5.
